csr_regfile: RTL and testbench

Machine/supervisor CSR storage that terminates the CSR write port driven by the trap controller (`clint`) and feeds back every CSR value that controller reads. It also serves the pipeline's CSR-instruction read/write path and keeps the current privilege level and free-running counters. Sits beside the WB stage, one instance per hart.

---
 rtl/csr_regfile.sv | 248 ++++++++++++++++++++++++
 tb/tb_csr_regfile.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - M/S CSR storage, privilege level and counters for one hart
// Define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise the counter addresses read 0.
module csr_regfile #(
  parameter logic [31:0] HART_ID = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_we_i,
  input  logic [11:0] trap_waddr_i,
  input  logic [31:0] trap_wdata_i,
  input  logic        inst_we_i,
  input  logic [11:0] inst_waddr_i,
  input  logic [31:0] inst_wdata_i,
  input  logic [11:0] inst_raddr_i,
  output logic [31:0] inst_rdata_o,
  output logic        inst_illegal_o,
  input  logic [1:0]  privilege_i,
  input  logic        mtime_ge_i,
  input  logic        instret_i,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic [31:0] csr_mtval_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_medeleg_o,
  output logic [31:0] csr_mideleg_o,
  output logic [31:0] csr_stvec_o,
  output logic [31:0] csr_sepc_o,
  output logic [31:0] csr_scause_o,
  output logic [31:0] csr_stval_o,
  output logic [31:0] csr_sstatus_o,
  output logic [31:0] csr_sie_o,
  output logic [31:0] csr_sip_o,
  output logic [31:0] csr_satp_o,
  output logic [1:0]  csr_privilege_o
);

  localparam logic [31:0] SSTATUS_MASK = 32'h000C_0122;
  localparam logic [31:0] MIP_SW_MASK  = 32'h0000_0022;
  localparam logic [31:0] MISA_VALUE   = 32'h4014_1105;
  localparam logic [31:0] MSTATUS_RST  = 32'h0000_1800;

  logic [31:0] mstatus_q, medeleg_q, mideleg_q, mie_q, mtvec_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] mip_q, stvec_q, sepc_q, scause_q, stval_q, satp_q;
  logic [31:0] mstatus_n, medeleg_n, mideleg_n, mie_n, mtvec_n, mepc_n, mcause_n, mtval_n;
  logic [31:0] mip_n, stvec_n, sepc_n, scause_n, stval_n, satp_n;
  logic [1:0]  priv_q;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_n, minstret_q, minstret_n;
  logic        cycle_wr, instret_wr;
`else
  logic        unused_instret;
  assign unused_instret = instret_i;
`endif

  logic        port_we   [2];
  logic [11:0] port_addr [2];
  logic [31:0] port_data [2];
  logic        inst_drop;

  // Views of one register (sstatus/mstatus, sie/mie, sip/mip) count as the same target.
  function automatic logic [11:0] write_target(input logic [11:0] addr);
    case (addr)
      12'h100: write_target = 12'h300;
      12'h104: write_target = 12'h304;
      12'h144: write_target = 12'h344;
      default: write_target = addr;
    endcase
  endfunction

  assign inst_drop    = trap_we_i && (write_target(trap_waddr_i) == write_target(inst_waddr_i));
  assign port_we[0]   = trap_we_i;
  assign port_addr[0] = trap_waddr_i;
  assign port_data[0] = trap_wdata_i;
  assign port_we[1]   = inst_we_i && !inst_drop;
  assign port_addr[1] = inst_waddr_i;
  assign port_data[1] = inst_wdata_i;

  always_comb begin
    mstatus_n = mstatus_q;
    medeleg_n = medeleg_q;
    mideleg_n = mideleg_q;
    mie_n     = mie_q;
    mtvec_n   = mtvec_q;
    mepc_n    = mepc_q;
    mcause_n  = mcause_q;
    mtval_n   = mtval_q;
    mip_n     = mip_q;
    stvec_n   = stvec_q;
    sepc_n    = sepc_q;
    scause_n  = scause_q;
    stval_n   = stval_q;
    satp_n    = satp_q;
`ifdef CSR_COUNTERS_EN
    mcycle_n   = mcycle_q;
    minstret_n = minstret_q;
    cycle_wr   = 1'b0;
    instret_wr = 1'b0;
`endif
    for (int p = 0; p < 2; p++) begin
      if (port_we[p]) begin
        case (port_addr[p])
          12'h300: mstatus_n = port_data[p];
          12'h100: mstatus_n = (mstatus_n & ~SSTATUS_MASK) | (port_data[p] & SSTATUS_MASK);
          12'h302: medeleg_n = port_data[p];
          12'h303: mideleg_n = port_data[p];
          12'h304: mie_n     = port_data[p];
          12'h104: mie_n     = (mie_n & ~mideleg_q) | (port_data[p] & mideleg_q);
          12'h305: mtvec_n   = port_data[p];
          12'h341: mepc_n    = {port_data[p][31:1], 1'b0};
          12'h342: mcause_n  = port_data[p];
          12'h343: mtval_n   = port_data[p];
          12'h344: mip_n     = (mip_n & ~MIP_SW_MASK) | (port_data[p] & MIP_SW_MASK);
          12'h144: mip_n     = (mip_n & ~(MIP_SW_MASK & mideleg_q))
                             | (port_data[p] & MIP_SW_MASK & mideleg_q);
          12'h105: stvec_n   = port_data[p];
          12'h141: sepc_n    = {port_data[p][31:1], 1'b0};
          12'h142: scause_n  = port_data[p];
          12'h143: stval_n   = port_data[p];
          12'h180: satp_n    = port_data[p];
`ifdef CSR_COUNTERS_EN
          12'hB00: begin mcycle_n[31:0]    = port_data[p]; cycle_wr   = 1'b1; end
          12'hB80: begin mcycle_n[63:32]   = port_data[p]; cycle_wr   = 1'b1; end
          12'hB02: begin minstret_n[31:0]  = port_data[p]; instret_wr = 1'b1; end
          12'hB82: begin minstret_n[63:32] = port_data[p]; instret_wr = 1'b1; end
`endif
          default: ;
        endcase
      end
    end
    // MTIP mirrors the timer comparator regardless of any write this cycle.
    mip_n[7] = mtime_ge_i;
`ifdef CSR_COUNTERS_EN
    if (!cycle_wr)                 mcycle_n   = mcycle_q + 64'd1;
    if (!instret_wr && instret_i)  minstret_n = minstret_q + 64'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_q <= MSTATUS_RST;
      medeleg_q <= '0;
      mideleg_q <= '0;
      mie_q     <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtval_q   <= '0;
      mip_q     <= '0;
      stvec_q   <= '0;
      sepc_q    <= '0;
      scause_q  <= '0;
      stval_q   <= '0;
      satp_q    <= '0;
      priv_q    <= 2'b11;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= '0;
      minstret_q <= '0;
`endif
    end else begin
      mstatus_q <= mstatus_n;
      medeleg_q <= medeleg_n;
      mideleg_q <= mideleg_n;
      mie_q     <= mie_n;
      mtvec_q   <= mtvec_n;
      mepc_q    <= mepc_n;
      mcause_q  <= mcause_n;
      mtval_q   <= mtval_n;
      mip_q     <= mip_n;
      stvec_q   <= stvec_n;
      sepc_q    <= sepc_n;
      scause_q  <= scause_n;
      stval_q   <= stval_n;
      satp_q    <= satp_n;
      priv_q    <= privilege_i;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= mcycle_n;
      minstret_q <= minstret_n;
`endif
    end
  end

  logic [31:0] rd_value;
  logic        rd_implemented;

  always_comb begin
    rd_value       = '0;
    rd_implemented = 1'b1;
    case (inst_raddr_i)
      12'h300: rd_value = mstatus_q;
      12'h301: rd_value = MISA_VALUE;
      12'h302: rd_value = medeleg_q;
      12'h303: rd_value = mideleg_q;
      12'h304: rd_value = mie_q;
      12'h305: rd_value = mtvec_q;
      12'h341: rd_value = mepc_q;
      12'h342: rd_value = mcause_q;
      12'h343: rd_value = mtval_q;
      12'h344: rd_value = mip_q;
      12'h100: rd_value = mstatus_q & SSTATUS_MASK;
      12'h104: rd_value = mie_q & mideleg_q;
      12'h105: rd_value = stvec_q;
      12'h141: rd_value = sepc_q;
      12'h142: rd_value = scause_q;
      12'h143: rd_value = stval_q;
      12'h144: rd_value = mip_q & mideleg_q;
      12'h180: rd_value = satp_q;
      12'hF11, 12'hF12: rd_value = '0;
      12'hF14: rd_value = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: rd_value = mcycle_q[31:0];
      12'hB80, 12'hC80: rd_value = mcycle_q[63:32];
      12'hB02, 12'hC02: rd_value = minstret_q[31:0];
      12'hB82, 12'hC82: rd_value = minstret_q[63:32];
`else
      12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: rd_value = '0;
`endif
      default: rd_implemented = 1'b0;
    endcase
  end

  assign inst_illegal_o = !rd_implemented || (inst_raddr_i[9:8] > priv_q);
  assign inst_rdata_o   = inst_illegal_o ? '0 : rd_value;

  assign csr_mstatus_o   = mstatus_q;
  assign csr_mtvec_o     = mtvec_q;
  assign csr_mepc_o      = mepc_q;
  assign csr_mcause_o    = mcause_q;
  assign csr_mtval_o     = mtval_q;
  assign csr_mie_o       = mie_q;
  assign csr_mip_o       = mip_q;
  assign csr_medeleg_o   = medeleg_q;
  assign csr_mideleg_o   = mideleg_q;
  assign csr_stvec_o     = stvec_q;
  assign csr_sepc_o      = sepc_q;
  assign csr_scause_o    = scause_q;
  assign csr_stval_o     = stval_q;
  assign csr_sstatus_o   = mstatus_q & SSTATUS_MASK;
  assign csr_sie_o       = mie_q & mideleg_q;
  assign csr_sip_o       = mip_q & mideleg_q;
  assign csr_satp_o      = satp_q;
  assign csr_privilege_o = priv_q;

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - self-checking bench for csr_regfile with a behavioural CSR model
module tb_csr_regfile;

  localparam logic [31:0] HID   = 32'd5;
  localparam logic [31:0] SMASK = 32'h000C_0122;
`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_we, inst_we, mtime_ge, instret;
  logic [11:0] trap_waddr, inst_waddr, inst_raddr;
  logic [31:0] trap_wdata, inst_wdata, inst_rdata;
  logic        inst_illegal;
  logic [1:0]  privilege, csr_privilege;
  logic [31:0] o_mstatus, o_mtvec, o_mepc, o_mcause, o_mtval, o_mie, o_mip, o_medeleg, o_mideleg;
  logic [31:0] o_stvec, o_sepc, o_scause, o_stval, o_sstatus, o_sie, o_sip, o_satp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_regfile #(.HART_ID(HID)) dut (
    .clk(clk), .rst(rst),
    .trap_we_i(trap_we), .trap_waddr_i(trap_waddr), .trap_wdata_i(trap_wdata),
    .inst_we_i(inst_we), .inst_waddr_i(inst_waddr), .inst_wdata_i(inst_wdata),
    .inst_raddr_i(inst_raddr), .inst_rdata_o(inst_rdata), .inst_illegal_o(inst_illegal),
    .privilege_i(privilege), .mtime_ge_i(mtime_ge), .instret_i(instret),
    .csr_mstatus_o(o_mstatus), .csr_mtvec_o(o_mtvec), .csr_mepc_o(o_mepc),
    .csr_mcause_o(o_mcause), .csr_mtval_o(o_mtval), .csr_mie_o(o_mie), .csr_mip_o(o_mip),
    .csr_medeleg_o(o_medeleg), .csr_mideleg_o(o_mideleg), .csr_stvec_o(o_stvec),
    .csr_sepc_o(o_sepc), .csr_scause_o(o_scause), .csr_stval_o(o_stval),
    .csr_sstatus_o(o_sstatus), .csr_sie_o(o_sie), .csr_sip_o(o_sip), .csr_satp_o(o_satp),
    .csr_privilege_o(csr_privilege)
  );

  logic [31:0] outs [17];
  string       out_names [17] = '{"mstatus", "mtvec", "mepc", "mcause", "mtval", "mie", "mip",
                                  "medeleg", "mideleg", "stvec", "sepc", "scause", "stval",
                                  "sstatus", "sie", "sip", "satp"};
  always_comb outs = '{o_mstatus, o_mtvec, o_mepc, o_mcause, o_mtval, o_mie, o_mip, o_medeleg,
                       o_mideleg, o_stvec, o_sepc, o_scause, o_stval, o_sstatus, o_sie, o_sip, o_satp};

  // Reference model: storage keyed by architectural address, views derived on read.
  logic [31:0] mreg [int];
  logic [63:0] m_cyc, m_ins;
  logic [1:0]  m_priv;
  logic [31:0] m_deleg_old;
  bit          m_cyc_w, m_ins_w;
  int          store_addr [14] = '{'h300, 'h302, 'h303, 'h304, 'h305, 'h341, 'h342, 'h343, 'h344,
                                   'h105, 'h141, 'h142, 'h143, 'h180};
  logic [11:0] addr_tbl [32] = '{12'h300, 12'h301, 12'h302, 12'h303, 12'h304, 12'h305, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'h100, 12'h104, 12'h105, 12'h141,
                                 12'h142, 12'h143, 12'h144, 12'h180, 12'hF11, 12'hF12, 12'hF14,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                                 12'hC82, 12'h340, 12'h7C0, 12'hF13};

  function automatic int canon(int a);
    if (a == 'h100) return 'h300;
    if (a == 'h104) return 'h304;
    if (a == 'h144) return 'h344;
    return a;
  endfunction

  task automatic model_reset();
    foreach (store_addr[i]) mreg[store_addr[i]] = 32'h0;
    mreg['h300] = 32'h0000_1800;
    m_priv = 2'b11;
    m_cyc  = 64'd0;
    m_ins  = 64'd0;
  endtask

  task automatic model_write(int a, logic [31:0] d);
    logic [31:0] t;
    case (a)
      'h300, 'h302, 'h303, 'h304, 'h305, 'h342, 'h343, 'h105, 'h142, 'h143, 'h180: mreg[a] = d;
      'h341, 'h141: mreg[a] = {d[31:1], 1'b0};
      'h100: mreg['h300] = (mreg['h300] & ~SMASK) | (d & SMASK);
      'h104: mreg['h304] = (mreg['h304] & ~m_deleg_old) | (d & m_deleg_old);
      'h344: begin t = mreg['h344]; t[1] = d[1]; t[5] = d[5]; mreg['h344] = t; end
      'h144: begin
        t = mreg['h344];
        if (m_deleg_old[1]) t[1] = d[1];
        if (m_deleg_old[5]) t[5] = d[5];
        mreg['h344] = t;
      end
      'hB00: if (CNT) begin m_cyc[31:0]  = d; m_cyc_w = 1; end
      'hB80: if (CNT) begin m_cyc[63:32] = d; m_cyc_w = 1; end
      'hB02: if (CNT) begin m_ins[31:0]  = d; m_ins_w = 1; end
      'hB82: if (CNT) begin m_ins[63:32] = d; m_ins_w = 1; end
      default: ;
    endcase
  endtask

  task automatic model_step();
    logic [31:0] t;
    if (!rst) begin
      model_reset();
      return;
    end
    m_cyc_w = 0;
    m_ins_w = 0;
    m_deleg_old = mreg['h303];
    if (trap_we) model_write(int'(trap_waddr), trap_wdata);
    if (inst_we && !(trap_we && canon(int'(trap_waddr)) == canon(int'(inst_waddr))))
      model_write(int'(inst_waddr), inst_wdata);
    t = mreg['h344];
    t[7] = mtime_ge;
    mreg['h344] = t;
    if (!m_cyc_w) m_cyc = m_cyc + 64'd1;
    if (!m_ins_w && instret) m_ins = m_ins + 64'd1;
    m_priv = privilege;
  endtask

  task automatic model_read(int a, output logic [31:0] v, output logic ill);
    bit impl = 1;
    v = 32'h0;
    case (a)
      'h300, 'h302, 'h303, 'h304, 'h305, 'h341, 'h342, 'h343, 'h344,
      'h105, 'h141, 'h142, 'h143, 'h180: v = mreg[a];
      'h100: v = mreg['h300] & SMASK;
      'h104: v = mreg['h304] & mreg['h303];
      'h144: v = mreg['h344] & mreg['h303];
      'h301: v = 32'h4014_1105;
      'hF11, 'hF12: v = 32'h0;
      'hF14: v = HID;
      'hB00, 'hC00: v = CNT ? m_cyc[31:0]  : 32'h0;
      'hB80, 'hC80: v = CNT ? m_cyc[63:32] : 32'h0;
      'hB02, 'hC02: v = CNT ? m_ins[31:0]  : 32'h0;
      'hB82, 'hC82: v = CNT ? m_ins[63:32] : 32'h0;
      default: impl = 0;
    endcase
    ill = !impl || (2'(a >> 8) > m_priv);
    if (ill) v = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    trap_we = 1'b0;
    inst_we = 1'b0;
  endtask

  task automatic trap_wr(logic [11:0] a, logic [31:0] d);
    trap_we = 1'b1; trap_waddr = a; trap_wdata = d;
  endtask

  task automatic inst_wr(logic [11:0] a, logic [31:0] d);
    inst_we = 1'b1; inst_waddr = a; inst_wdata = d;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 17; i++) begin
      exp = (i == 0) ? 32'h0000_1800 : 32'h0;
      checks++;
      if (outs[i] !== exp) begin
        errors++;
        $display("FAIL reset_%s: got %h expected %h", out_names[i], outs[i], exp);
      end
    end
    checks++;
    if (csr_privilege !== 2'b11) begin
      errors++;
      $display("FAIL reset_privilege: got %b expected 11", csr_privilege);
    end
    rst = 1'b1;
    tick();
    tick();
    tick();
    inst_raddr = 12'hB00;
    #1;
`ifdef CSR_COUNTERS_EN
    exp = 32'd3;
`else
    exp = 32'd0;
`endif
    checks++;
    if (inst_rdata !== exp || inst_illegal !== 1'b0) begin
      errors++;
      $display("FAIL mcycle_after_release: got %h/%b expected %h/0", inst_rdata, inst_illegal, exp);
    end
    inst_raddr = 12'hF14;
    #1;
    checks++;
    if (inst_rdata !== HID) begin
      errors++;
      $display("FAIL mhartid: got %h expected %h", inst_rdata, HID);
    end
  endtask

  task automatic test_trap_sequence();
    trap_wr(12'h341, 32'h8000_0103); tick();
    checks++;
    if (o_mepc !== 32'h8000_0102) begin
      errors++;
      $display("FAIL trap_mepc_lsb: got %h expected 80000102", o_mepc);
    end
    trap_wr(12'h342, 32'h8000_0007); tick();
    trap_wr(12'h300, 32'h0000_1880); tick();
    idle();
    checks++;
    if (o_mepc !== 32'h8000_0102 || o_mcause !== 32'h8000_0007 || o_mstatus !== 32'h0000_1880) begin
      errors++;
      $display("FAIL trap_sequence: got mepc=%h mcause=%h mstatus=%h expected 80000102 80000007 00001880",
               o_mepc, o_mcause, o_mstatus);
    end
    inst_raddr = 12'h342;
    #1;
    checks++;
    if (inst_rdata !== 32'h8000_0007) begin
      errors++;
      $display("FAIL read_mcause: got %h expected 80000007", inst_rdata);
    end
  endtask

  task automatic test_same_address();
    trap_wr(12'h300, 32'h0000_1888);
    inst_wr(12'h100, 32'h0000_0002);
    tick();
    idle();
    checks++;
    if (o_mstatus !== 32'h0000_1888 || o_sstatus !== 32'h0) begin
      errors++;
      $display("FAIL mstatus_conflict: got mstatus=%h sstatus=%h expected 00001888 00000000",
               o_mstatus, o_sstatus);
    end
    trap_wr(12'h305, 32'hAAAA_0000);
    inst_wr(12'h305, 32'h5555_0000);
    tick();
    idle();
    checks++;
    if (o_mtvec !== 32'hAAAA_0000) begin
      errors++;
      $display("FAIL mtvec_conflict: got %h expected aaaa0000", o_mtvec);
    end
    trap_wr(12'h343, 32'h1234_5678);
    inst_wr(12'h105, 32'h8765_4320);
    tick();
    idle();
    checks++;
    if (o_mtval !== 32'h1234_5678 || o_stvec !== 32'h8765_4320) begin
      errors++;
      $display("FAIL dual_write: got mtval=%h stvec=%h expected 12345678 87654320", o_mtval, o_stvec);
    end
  endtask

  task automatic test_delegated();
    trap_wr(12'h303, 32'h0000_0020); tick(); idle();
    inst_wr(12'h104, 32'hFFFF_FFFF); tick(); idle();
    checks++;
    if (o_mie !== 32'h20 || o_sie !== 32'h20) begin
      errors++;
      $display("FAIL sie_write: got mie=%h sie=%h expected 00000020 00000020", o_mie, o_sie);
    end
    inst_wr(12'h100, 32'hFFFF_FFFF); tick(); idle();
    checks++;
    if (o_sstatus !== 32'h000C_0122 || o_mstatus !== 32'h000C_19AA) begin
      errors++;
      $display("FAIL sstatus_write: got sstatus=%h mstatus=%h expected 000c0122 000c19aa",
               o_sstatus, o_mstatus);
    end
    inst_wr(12'h144, 32'hFFFF_FFFF); tick(); idle();
    checks++;
    if (o_mip !== 32'h20 || o_sip !== 32'h20) begin
      errors++;
      $display("FAIL sip_write: got mip=%h sip=%h expected 00000020 00000020", o_mip, o_sip);
    end
  endtask

  task automatic test_priv_mtip();
    logic [31:0] ev;
    logic        ei;
    privilege = 2'b00; tick();
    inst_raddr = 12'h300; #1;
    checks++;
    if (inst_illegal !== 1'b1 || inst_rdata !== 32'h0) begin
      errors++;
      $display("FAIL user_read_mstatus: got ill=%b data=%h expected 1 00000000", inst_illegal, inst_rdata);
    end
    inst_raddr = 12'hC00; #1;
    model_read('hC00, ev, ei);
    checks++;
    if (inst_illegal !== 1'b0 || inst_rdata !== ev) begin
      errors++;
      $display("FAIL user_read_cycle: got ill=%b data=%h expected 0 %h", inst_illegal, inst_rdata, ev);
    end
    privilege = 2'b01; tick();
    inst_raddr = 12'h100; #1;
    checks++;
    if (inst_illegal !== 1'b0 || inst_rdata !== 32'h000C_0122) begin
      errors++;
      $display("FAIL super_read_sstatus: got ill=%b data=%h expected 0 000c0122", inst_illegal, inst_rdata);
    end
    inst_raddr = 12'h304; #1;
    checks++;
    if (inst_illegal !== 1'b1) begin
      errors++;
      $display("FAIL super_read_mie: got ill=%b expected 1", inst_illegal);
    end
    privilege = 2'b11; tick();
    inst_raddr = 12'h7C0; #1;
    checks++;
    if (inst_illegal !== 1'b1 || inst_rdata !== 32'h0) begin
      errors++;
      $display("FAIL unimplemented_read: got ill=%b data=%h expected 1 00000000", inst_illegal, inst_rdata);
    end
    mtime_ge = 1'b1; tick();
    checks++;
    if (o_mip[7] !== 1'b1) begin
      errors++;
      $display("FAIL mtip_set: got %b expected 1", o_mip[7]);
    end
    trap_wr(12'h344, 32'h0); tick(); idle();
    checks++;
    if (o_mip !== 32'h80) begin
      errors++;
      $display("FAIL mtip_write_ignored: got %h expected 00000080", o_mip);
    end
    trap_wr(12'hF14, 32'hFFFF_FFFF);
    inst_wr(12'h301, 32'h0);
    tick(); idle();
    inst_raddr = 12'h301; #1;
    checks++;
    if (inst_rdata !== 32'h4014_1105 || inst_illegal !== 1'b0) begin
      errors++;
      $display("FAIL misa_readonly: got %h/%b expected 40141105/0", inst_rdata, inst_illegal);
    end
    inst_raddr = 12'hF14; #1;
    checks++;
    if (inst_rdata !== HID) begin
      errors++;
      $display("FAIL mhartid_readonly: got %h expected %h", inst_rdata, HID);
    end
    mtime_ge = 1'b0; tick();
  endtask

  task automatic test_counters();
    logic [63:0] got;
`ifdef CSR_COUNTERS_EN
    logic [63:0] want [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h1,
                              64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000};
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: begin trap_wr(12'hB00, 32'hFFFF_FFFF); inst_wr(12'hB80, 32'hFFFF_FFFF); end
        2: trap_wr(12'hB00, 32'h0);
        4: trap_wr(12'hB00, 32'hFFFF_FFFF);
        default: ;
      endcase
      tick(); idle();
      inst_raddr = 12'hB00; #1; got[31:0] = inst_rdata;
      inst_raddr = 12'hB80; #1; got[63:32] = inst_rdata;
      checks++;
      if (got !== want[s]) begin
        errors++;
        $display("FAIL mcycle_step%0d: got %h expected %h", s, got, want[s]);
      end
    end
    instret = 1'b1;
    trap_wr(12'hB02, 32'd5);
    inst_wr(12'hB82, 32'd0);
    tick(); idle();
    instret = 1'b0; tick();
    instret = 1'b1; tick();
    instret = 1'b0;
    privilege = 2'b00; tick();
    inst_raddr = 12'hC02; #1; got[31:0] = inst_rdata;
    inst_raddr = 12'hC82; #1; got[63:32] = inst_rdata;
    checks++;
    if (got !== 64'd6) begin
      errors++;
      $display("FAIL minstret_alias: got %h expected 0000000000000006", got);
    end
    privilege = 2'b11; tick();
`else
    trap_wr(12'hB00, 32'h1234);
    inst_wr(12'hB82, 32'h5678);
    tick(); idle();
    for (int i = 21; i < 29; i++) begin
      inst_raddr = addr_tbl[i]; #1;
      got = {31'h0, inst_illegal, inst_rdata};
      checks++;
      if (got !== 64'h0) begin
        errors++;
        $display("FAIL counter_absent_%h: got ill=%b data=%h expected 0 00000000",
                 addr_tbl[i], inst_illegal, inst_rdata);
      end
    end
`endif
  endtask

  task automatic test_reset_midseq();
    trap_wr(12'h341, 32'h0000_1234); tick();
    rst = 1'b0;
    privilege = 2'b00;
    trap_wr(12'h342, 32'h0000_0007);
    tick(); idle();
    checks++;
    if (o_mepc !== 32'h0 || o_mcause !== 32'h0 || o_mstatus !== 32'h1800 || csr_privilege !== 2'b11) begin
      errors++;
      $display("FAIL reset_midseq: got mepc=%h mcause=%h mstatus=%h priv=%b expected 0 0 1800 11",
               o_mepc, o_mcause, o_mstatus, csr_privilege);
    end
    rst = 1'b1;
    privilege = 2'b11;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ev, exp_o [17];
    logic        ei;
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) != 0);
      trap_we    = $urandom_range(0, 1);
      trap_waddr = addr_tbl[$urandom_range(0, 31)];
      trap_wdata = $urandom;
      inst_we    = $urandom_range(0, 1);
      inst_waddr = ($urandom_range(0, 3) == 0) ? trap_waddr : addr_tbl[$urandom_range(0, 31)];
      inst_wdata = $urandom;
      mtime_ge   = $urandom_range(0, 1);
      instret    = $urandom_range(0, 1);
      privilege  = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      inst_raddr = addr_tbl[$urandom_range(0, 31)];
      #1;
      model_read(int'(inst_raddr), ev, ei);
      checks++;
      if (inst_rdata !== ev || inst_illegal !== ei) begin
        errors++;
        $display("FAIL rand_read_%h: got %h/%b expected %h/%b", inst_raddr, inst_rdata, inst_illegal, ev, ei);
      end
      tick();
      exp_o = '{mreg['h300], mreg['h305], mreg['h341], mreg['h342], mreg['h343], mreg['h304],
                mreg['h344], mreg['h302], mreg['h303], mreg['h105], mreg['h141], mreg['h142],
                mreg['h143], mreg['h300] & SMASK, mreg['h304] & mreg['h303],
                mreg['h344] & mreg['h303], mreg['h180]};
      for (int i = 0; i < 17; i++) begin
        checks++;
        if (outs[i] !== exp_o[i]) begin
          errors++;
          $display("FAIL rand_%s: got %h expected %h", out_names[i], outs[i], exp_o[i]);
        end
      end
      checks++;
      if (csr_privilege !== m_priv) begin
        errors++;
        $display("FAIL rand_privilege: got %b expected %b", csr_privilege, m_priv);
      end
    end
    rst = 1'b1;
    idle();
  endtask

  initial begin
    rst = 1'b0; trap_we = 1'b0; inst_we = 1'b0;
    trap_waddr = '0; trap_wdata = '0; inst_waddr = '0; inst_wdata = '0; inst_raddr = '0;
    privilege = 2'b11; mtime_ge = 1'b0; instret = 1'b0;
    model_reset();
    test_reset();
    test_trap_sequence();
    test_same_address();
    test_delegated();
    test_priv_mtip();
    test_counters();
    test_reset_midseq();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
